// File: rtl/block_transfer_unit_pkg.sv
// Shared types and constants for the LDM/STM block transfer sequencer.
package block_transfer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_FINISH
  } bt_state_t;

  // Addressing mode encodings as {P, U}.
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/block_transfer_unit_lowest_set_bit16.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set_bit16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!valid && vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_transfer_unit.sv
// LDM/STM sequencer: one memory word access per listed register, ascending,
// followed by optional base writeback in FINISH.
module block_transfer_unit
  import block_transfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  write_back,
  input  logic                  pre_index,
  input  logic                  up,
  input  logic [15:0]           reg_list,
  input  logic [3:0]            base_reg_addr,
  input  logic [DATA_WIDTH-1:0] base_value,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            reg_read_addr,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  output logic                  reg_write_enable,
  output logic [3:0]            reg_write_addr,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  base_write_enable,
  output logic [3:0]            base_write_addr,
  output logic [DATA_WIDTH-1:0] base_write_data,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  bt_state_t             state;
  logic                  load_q, wb_q, pre_q, up_q;
  logic [15:0]           list_q, mask_q, next_mask;
  logic [3:0]            base_addr_q, cur_reg;
  logic                  cur_valid, base_we_next;
  logic [DATA_WIDTH-1:0] base_q, span, step, first_addr, final_base;
  logic [4:0]            cnt;

  lowest_set_bit16 u_lsb (
    .vec  (mask_q),
    .idx  (cur_reg),
    .valid(cur_valid)
  );

  always_comb begin
    cnt        = popcount16(list_q);
    step       = DATA_WIDTH'(WORD_BYTES);
    span       = DATA_WIDTH'(cnt) * step;
    final_base = up_q ? base_q + span : base_q - span;
    case ({pre_q, up_q})
      MODE_IA: first_addr = base_q;
      MODE_IB: first_addr = base_q + step;
      MODE_DA: first_addr = base_q - span + step;
      default: first_addr = base_q - span;
    endcase
    next_mask    = mask_q & (mask_q - 16'd1);
    // A loaded base value takes precedence over the writeback.
    base_we_next = wb_q && (cnt != 5'd0) && !(load_q && list_q[base_addr_q]);
  end

  // Store data passes straight from the register file read port.
  assign reg_read_addr = (state == S_XFER && !load_q) ? cur_reg : '0;
  assign mem_wdata     = (state == S_XFER && !load_q) ? reg_read_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      load_q            <= 1'b0;
      wb_q              <= 1'b0;
      pre_q             <= 1'b0;
      up_q              <= 1'b0;
      list_q            <= '0;
      mask_q            <= '0;
      base_addr_q       <= '0;
      base_q            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      reg_write_enable  <= 1'b0;
      reg_write_addr    <= '0;
      reg_write_data    <= '0;
      base_write_enable <= 1'b0;
      base_write_addr   <= '0;
      base_write_data   <= '0;
      mem_req           <= 1'b0;
      mem_write         <= 1'b0;
      mem_addr          <= '0;
    end else begin
      done              <= 1'b0;
      reg_write_enable  <= 1'b0;
      base_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            load_q      <= is_load;
            wb_q        <= write_back;
            pre_q       <= pre_index;
            up_q        <= up;
            list_q      <= reg_list;
            base_addr_q <= base_reg_addr;
            base_q      <= base_value;
            busy        <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          mask_q          <= list_q;
          base_write_addr <= base_addr_q;
          base_write_data <= final_base;
          if (cnt != 5'd0) begin
            state     <= S_XFER;
            mem_req   <= 1'b1;
            mem_write <= !load_q;
            mem_addr  <= first_addr;
          end else begin
            state <= S_FINISH;
            done  <= 1'b1;
          end
        end
        S_XFER: begin
          if (mem_ready && cur_valid) begin
            mask_q <= next_mask;
            if (load_q) begin
              reg_write_enable <= 1'b1;
              reg_write_addr   <= cur_reg;
              reg_write_data   <= mem_rdata;
            end
            if (next_mask == '0) begin
              state             <= S_FINISH;
              mem_req           <= 1'b0;
              mem_write         <= 1'b0;
              mem_addr          <= '0;
              done              <= 1'b1;
              base_write_enable <= base_we_next;
            end else begin
              mem_addr <= mem_addr + step;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_transfer_unit.sv
// Randomized bench for block_transfer_unit against a queue-based transfer model.
module tb_block_transfer_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0, is_load = 1'b0, write_back = 1'b0, pre_index = 1'b0, up = 1'b0;
  logic [15:0] reg_list = '0;
  logic [3:0]  base_reg_addr = '0;
  logic [31:0] base_value = '0;
  logic        busy, done, reg_write_enable, base_write_enable, mem_req, mem_write;
  logic [3:0]  reg_read_addr, reg_write_addr, base_write_addr;
  logic [31:0] reg_read_data, reg_write_data, base_write_data, mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rf [16];

  assign reg_read_data = rf[reg_read_addr];
  always #5 clk = ~clk;

  block_transfer_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
    .write_back(write_back), .pre_index(pre_index), .up(up), .reg_list(reg_list),
    .base_reg_addr(base_reg_addr), .base_value(base_value), .busy(busy), .done(done),
    .reg_read_addr(reg_read_addr), .reg_read_data(reg_read_data),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .base_write_enable(base_write_enable),
    .base_write_addr(base_write_addr), .base_write_data(base_write_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] r; logic wr; } beat_t;
  typedef struct { logic [3:0] r; logic [31:0] d; } wr_t;

  beat_t       exp_beats[$];
  wr_t         exp_wr[$], obs_wr[$];
  logic [31:0] obs_addr[$], obs_data[$], rdata_q[$];
  int          total = 0, bad = 0;
  int          hs_count = 0, req_cycles = 0, wait_left = 0, stall_mode = 0;
  int          done_k = 0, busy_n = 0, exp_n = 0;
  logic        op_active = 1'b0, exp_bwe = 1'b0, bwe_seen = 1'b0;
  logic [3:0]  exp_baddr = '0;
  logic [31:0] exp_bdata = '0, obs_bdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int next_stall();
    if (stall_mode >= 0) return stall_mode;
    return int'($urandom_range(0, 3));
  endfunction

  // Memory responder and per-cycle compare against the expected transfer queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ready = 1'b0;
    end else begin
      if (reg_write_enable) begin
        obs_wr.push_back('{r: reg_write_addr, d: reg_write_data});
        if (exp_wr.size() == 0) chk("reg_write_without_expect", reg_write_enable, 1'b0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("reg_write_addr", reg_write_addr, w.r);
          chk("reg_write_data", reg_write_data, w.d);
        end
      end
      if (mem_req) begin
        req_cycles++;
        if (exp_beats.size() == 0) chk("mem_req_without_beat", mem_req, 1'b0);
        else begin
          beat_t b;
          b = exp_beats[0];
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_write", mem_write, b.wr);
          if (b.wr) begin
            chk("reg_read_addr", reg_read_addr, b.r);
            chk("mem_wdata", mem_wdata, rf[b.r]);
          end
          if (wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
            if (!b.wr) exp_wr.push_back('{r: b.r, d: mem_rdata});
            obs_addr.push_back(mem_addr);
            obs_data.push_back(b.wr ? mem_wdata : mem_rdata);
            void'(exp_beats.pop_front());
            hs_count++;
            wait_left = next_stall();
          end
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (base_write_enable) begin
        bwe_seen  = 1'b1;
        obs_bdata = base_write_data;
      end
      if (done) begin
        if (!op_active) chk("done_without_op", done, 1'b0);
        else begin
          chk("base_write_enable", base_write_enable, exp_bwe);
          if (exp_bwe) begin
            chk("base_write_addr", base_write_addr, exp_baddr);
            chk("base_write_data", base_write_data, exp_bdata);
          end
          chk("beats_left_at_done", exp_beats.size(), 0);
          chk("writes_left_at_done", exp_wr.size(), 0);
          op_active = 1'b0;
        end
      end else if (base_write_enable) begin
        chk("base_we_outside_done", base_write_enable, 1'b0);
      end
    end
  end

  task automatic launch(input logic ld, input logic wb, input logic p, input logic u,
                        input logic [15:0] lst, input logic [3:0] ba, input logic [31:0] bv);
    int n;
    logic [31:0] a;
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    exp_n = n;
    if (u) a = p ? bv + 32'd4 : bv;
    else   a = p ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4;
    for (int i = 0; i < 16; i++)
      if (lst[i]) begin
        exp_beats.push_back('{addr: a, r: 4'(i), wr: !ld});
        a = a + 32'd4;
      end
    exp_bdata = u ? bv + 32'(4 * n) : bv - 32'(4 * n);
    exp_baddr = ba;
    exp_bwe   = wb && (n > 0) && !(ld && lst[ba]);
    rf[ba]    = bv;
    op_active = 1'b1;
    wait_left = next_stall();
    is_load = ld; write_back = wb; pre_index = p; up = u;
    reg_list = lst; base_reg_addr = ba; base_value = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    is_load = 1'($urandom); write_back = 1'($urandom); pre_index = 1'($urandom);
    up = 1'($urandom); reg_list = 16'($urandom); base_reg_addr = 4'($urandom);
    base_value = $urandom;
  endtask

  task automatic wait_done(input logic check_timing);
    int k;
    logic got;
    k = 0; got = 1'b0; busy_n = 0; done_k = -1;
    while (!got && k < 400) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        done_k = k;
      end
      k++;
    end
    chk("done_seen", got, 1'b1);
    if (check_timing && got) begin
      chk("done_cycle", done_k, exp_n + 1);
      chk("busy_cycles", busy_n, exp_n + 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_wr.delete();
    bwe_seen = 1'b0; obs_bdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_reg_read_addr"}, reg_read_addr, 4'h0);
    chk({tag, "_reg_we"}, reg_write_enable, 1'b0);
    chk({tag, "_reg_waddr"}, reg_write_addr, 4'h0);
    chk({tag, "_reg_wdata"}, reg_write_data, 32'h0);
    chk({tag, "_base_we"}, base_write_enable, 1'b0);
    chk({tag, "_base_waddr"}, base_write_addr, 4'h0);
    chk({tag, "_base_wdata"}, base_write_data, 32'h0);
  endtask

  initial begin
    int hs0, rq0, k;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // STM IA, zero-wait
    stall_mode = 0; clear_obs(); hs0 = hs_count;
    rf[1] = 32'h11; rf[2] = 32'h22;
    launch(1'b0, 1'b1, 1'b0, 1'b1, 16'h0006, 4'd5, 32'h100);
    wait_done(1'b1);
    chk("t1_done_cycle", done_k, 3);
    chk("t1_busy_cycles", busy_n, 4);
    chk("t1_beats", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("t1_addr0", obs_addr[0], 32'h100); chk("t1_data0", obs_data[0], 32'h11);
      chk("t1_addr1", obs_addr[1], 32'h104); chk("t1_data1", obs_data[1], 32'h22);
    end
    chk("t1_bwe", bwe_seen, 1'b1);
    chk("t1_bdata", obs_bdata, 32'h108);

    // LDM DB with r15
    clear_obs();
    rdata_q.push_back(32'hA); rdata_q.push_back(32'hB);
    launch(1'b1, 1'b1, 1'b1, 1'b0, 16'h8001, 4'd7, 32'h200);
    wait_done(1'b1);
    chk("t2_beats", obs_addr.size(), 2);
    chk("t2_writes", obs_wr.size(), 2);
    if (obs_addr.size() == 2 && obs_wr.size() == 2) begin
      chk("t2_addr0", obs_addr[0], 32'h1F8); chk("t2_addr1", obs_addr[1], 32'h1FC);
      chk("t2_wr0_reg", obs_wr[0].r, 4'd0);  chk("t2_wr0_data", obs_wr[0].d, 32'hA);
      chk("t2_wr1_reg", obs_wr[1].r, 4'd15); chk("t2_wr1_data", obs_wr[1].d, 32'hB);
    end
    chk("t2_bdata", obs_bdata, 32'h1F8);

    // STM IB with two stall cycles per beat
    stall_mode = 2; clear_obs(); hs0 = hs_count; rq0 = req_cycles;
    launch(1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 4'd9, 32'h40);
    wait_done(1'b0);
    chk("t3_handshakes", hs_count - hs0, 2);
    chk("t3_req_cycles", req_cycles - rq0, 6);
    if (obs_addr.size() == 2) begin
      chk("t3_addr0", obs_addr[0], 32'h44); chk("t3_addr1", obs_addr[1], 32'h48);
    end

    // LDM IA with base in list: no writeback
    stall_mode = 0; clear_obs();
    launch(1'b1, 1'b1, 1'b0, 1'b1, 16'h0018, 4'd3, 32'h300);
    wait_done(1'b1);
    chk("t4_bwe_never", bwe_seen, 1'b0);
    if (obs_addr.size() == 2 && obs_wr.size() == 2) begin
      chk("t4_addr0", obs_addr[0], 32'h300); chk("t4_addr1", obs_addr[1], 32'h304);
      chk("t4_wr0_reg", obs_wr[0].r, 4'd3);  chk("t4_wr1_reg", obs_wr[1].r, 4'd4);
    end else chk("t4_counts", obs_addr.size() + obs_wr.size(), 4);

    // Empty list
    clear_obs(); hs0 = hs_count;
    launch(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd2, 32'h500);
    wait_done(1'b1);
    chk("t5_done_cycle", done_k, 1);
    chk("t5_busy_cycles", busy_n, 2);
    chk("t5_no_access", hs_count - hs0, 0);
    chk("t5_no_writes", obs_wr.size(), 0);
    chk("t5_no_bwe", bwe_seen, 1'b0);

    // Asynchronous reset after first beat of a 4-register STM
    clear_obs(); hs0 = hs_count;
    launch(1'b0, 1'b1, 1'b0, 1'b1, 16'h00F0, 4'd1, 32'h800);
    k = 0;
    while (hs_count == hs0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #2 reset_n = 1'b0;
    #1 chk_zero("midrst");
    chk("midrst_beats", hs_count - hs0, 1);
    exp_beats.delete(); exp_wr.delete(); op_active = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_writeback", bwe_seen, 1'b0);
    chk("midrst_idle", busy, 1'b0);
    @(posedge clk);
    #1;

    // start pulse while busy must be ignored
    stall_mode = 1;
    launch(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 4'd6, 32'h900);
    @(posedge clk);
    #1 start = 1'b1; is_load = 1'b1; reg_list = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("ignored_start_idle", busy, 1'b0);
    end
    @(posedge clk);
    #1;

    // Clean run after the disturbances
    stall_mode = 0;
    launch(1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 4'd12, 32'hA00);
    wait_done(1'b1);

    // Randomized operations, back-to-back
    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      stall_mode = ($urandom_range(0, 1) == 0) ? 0 : -1;
      lst = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) lst = '0;
      launch(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), lst,
             4'($urandom), $urandom);
      wait_done(stall_mode == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_transfer_unit.md
# block_transfer_unit

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It sits between the decode/execute stage and the register file and data memory. For each set bit in a 16-bit register list it issues one word access to memory. On a store it is the initiator of the register file read port; on a load it drives the register file write port. At the end it optionally writes the updated base address back.

## Interface
- DATA_WIDTH, 32, register, address and memory data width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_load, write_back, pre_index, up  in  1 each  L, W, P, U bits of the instruction.
- reg_list  in  16  register list; bit i selects ri.
- base_reg_addr  in  4  base register number.
- base_value  in  32  base register contents at start.
- busy  out  1  high from SETUP through FINISH.
- done  out  1  one-cycle pulse in FINISH.
- reg_read_addr  out  4  STM source register.
- reg_read_data  in  32  combinational read data for reg_read_addr.
- reg_write_enable, reg_write_addr, reg_write_data  out  1/4/32  LDM destination write.
- base_write_enable, base_write_addr, base_write_data  out  1/4/32  base writeback.
- mem_req, mem_write  out  1 each  access request; mem_write high for STM.
- mem_addr, mem_wdata  out  32 each  word address and store data.
- mem_ready  in  1  access completes at the rising edge where mem_req && mem_ready.
- mem_rdata  in  32  load data, valid with mem_ready.

## Operation
- States: IDLE, SETUP, XFER, FINISH.
- IDLE → SETUP on start. start is ignored in every other state.
- SETUP latches the controls, the list (as a remaining mask), n = popcount(reg_list) and the start address:
  - IA (P=0, U=1): base.
  - IB (P=1, U=1): base+4.
  - DA (P=0, U=0): base−4n+4.
  - DB (P=1, U=0): base−4n.
  - Final base: U ? base+4n : base−4n. All arithmetic is modulo 2^32.
- SETUP → XFER if n>0; SETUP → FINISH if n=0. An empty list makes no memory access and no writeback.
- XFER, per beat:
  - The current register is the lowest set bit of the remaining mask. Registers are transferred in ascending order at ascending addresses.
  - mem_req=1, mem_addr=current address, mem_write=!is_load.
  - STM: reg_read_addr=current register, and mem_wdata=reg_read_data combinationally.
  - On a handshake: clear the current bit and add 4 to the address.
  - LDM: register mem_rdata and the register number; assert reg_write_enable for exactly one cycle on the next cycle.
  - XFER → FINISH on the handshake that clears the last bit.
- FINISH:
  - done=1.
  - base_write_enable=1 when write_back && n>0 && !(is_load && reg_list[base_reg_addr]). If the base is in an LDM list, the loaded value wins and the writeback is suppressed.
  - base_write_addr=base_reg_addr, base_write_data=final base.
  - The last LDM register write also occurs in this cycle. It never targets the base when the base writeback is enabled.
  - FINISH → IDLE.
- STM with the base in the list stores the original base value, because writeback happens only in FINISH.
- LDM to r15 drives reg_write_addr=15 like any other register; PC handling is outside this block.

## Timing
- Reset: state IDLE, and all outputs are 0 (busy, done, mem_req, mem_write, all enables, addresses and data). Reset takes effect immediately and asynchronously.
- Reset mid-operation: the operation is abandoned and no writeback occurs. Memory must accept mem_req dropping.
- Cycle 0 = the edge at which start is sampled.
  - busy rises after edge 0.
  - First mem_req: the cycle after edge 1.
- Zero-wait memory: one beat per cycle, and FINISH follows the last beat. Total busy = n+2 cycles, and done is in the last of them.
- While mem_ready=0: mem_req, mem_addr, mem_write and mem_wdata stay stable. For STM, the register file must not change reg_read_data during the stall.
- Back-to-back: start may be asserted in the cycle after FINISH.

## Structure
- Package block_transfer_pkg holds:
  - the state enum;
  - constants for the IA/IB/DA/DB mode encodings {P,U};
  - WORD_BYTES=4.
- Sub-module lowest_set_bit16: combinational 16→4 priority encoder plus valid flag, used for current-register selection.

## Test plan
- STM IA, base 0x100, list 0x0006, r1=0x11, r2=0x22, W=1, mem_ready tied 1 → writes 0x100←0x11 and 0x104←0x22; base write 0x108; done 3 cycles after edge 0; busy 4 cycles.
- LDM DB, base 0x200, list 0x8001, mem_rdata 0xA then 0xB, W=1 → addresses 0x1F8 and 0x1FC; r0←0xA, r15←0xB; base write 0x1F8.
- STM IB, base 0x40, list 0x0003, mem_ready low 2 cycles per beat → addresses 0x44 and 0x48; mem_addr/mem_wdata stable during stalls; exactly 2 handshakes.
- LDM IA with base r3 in list 0x0018, W=1 → r3 and r4 loaded from base and base+4; base_write_enable never asserts.
- Empty list with W=1 → no mem_req and no write enables; done 1 cycle after edge 0.
- Async reset after the first beat of a 4-register STM → all outputs 0 at once and no writeback; start during busy in the following run is ignored; a clean run completes normally.
